// File: rtl/in_channel_fsm.sv
// Receive FSM for one router input channel: frames header/payload/parity, forwards each accepted byte to the FIFO one cycle later.
// Sticky error flag on a zero-length header or a parity mismatch; i_ch_en low stalls with no state change.
module in_channel_fsm #(
    parameter int data_size       = 8,
    parameter int pkt_length_bits = 5,
    parameter int pkt_addr_bits   = data_size - pkt_length_bits
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_ch_en,
    input  logic [data_size-1:0] i_data_in,
    input  logic                 i_clr_errors,
    output logic                 o_busy,
    output logic                 o_error,
    output logic [data_size-1:0] o_data_out,
    output logic                 o_pkt_to_fifo_en
);

    typedef enum logic [1:0] {IDLE, PAYLOAD, PARITY} state_t;

    // The length field is whatever lies below the address field.
    localparam int LEN_MSB = data_size - pkt_addr_bits - 1;

    state_t                     state_q, state_d;
    logic [pkt_length_bits-1:0] cnt_q, cnt_d;
    logic [data_size-1:0]       par_q, par_d;
    logic                       busy_q, busy_d;
    logic                       err_q, err_d;
    logic [data_size-1:0]       dout_q, dout_d;
    logic                       wen_q, wen_d;
    logic [pkt_length_bits-1:0] hdr_len;

    assign hdr_len = i_data_in[LEN_MSB:0];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            par_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
            wen_q   <= wen_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        busy_d  = busy_q;
        dout_d  = dout_q;
        wen_d   = 1'b0;
        // Clear first so that an error event below overrides a coincident clear.
        err_d   = err_q & ~i_clr_errors;

        unique case (state_q)
            IDLE: begin
                if (i_ch_en && !err_q) begin
                    if (hdr_len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        dout_d  = i_data_in;
                        wen_d   = 1'b1;
                        par_d   = i_data_in;
                        cnt_d   = hdr_len;
                        busy_d  = 1'b1;
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (i_ch_en) begin
                    dout_d = i_data_in;
                    wen_d  = 1'b1;
                    par_d  = par_q ^ i_data_in;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == {{(pkt_length_bits-1){1'b0}}, 1'b1}) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (i_ch_en) begin
                    dout_d  = i_data_in;
                    wen_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (i_data_in != par_q) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_busy           = busy_q;
    assign o_error          = err_q;
    assign o_data_out       = dout_q;
    assign o_pkt_to_fifo_en = wen_q;

endmodule

// File: tb/tb_in_channel_fsm.sv
module tb_in_channel_fsm;

    logic       clk;
    logic       rstn;
    logic       ch_en;
    logic [7:0] data_in;
    logic       clr_errors;
    logic       busy;
    logic       error;
    logic [7:0] data_out;
    logic       fifo_en;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    in_channel_fsm #(.data_size(8), .pkt_length_bits(5)) dut (
        .i_clk            (clk),
        .i_rstn           (rstn),
        .i_ch_en          (ch_en),
        .i_data_in        (data_in),
        .i_clr_errors     (clr_errors),
        .o_busy           (busy),
        .o_error          (error),
        .o_data_out       (data_out),
        .o_pkt_to_fifo_en (fifo_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest byte still expected.
    always @(negedge clk) begin
        if (rstn && fifo_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 8'd1, 8'd0);
            end else begin
                check("fifo_data", data_out, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit fwd);
        ch_en   = 1'b1;
        data_in = b;
        if (fwd) exp_q.push_back(b);
        tick();
        ch_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        ch_en = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_err();
        clr_errors = 1'b1;
        idle(1);
        clr_errors = 1'b0;
        check("err_cleared", {7'd0, error}, 8'd0);
    endtask

    initial begin
        rstn = 1'b0; ch_en = 1'b0; data_in = 8'h00; clr_errors = 1'b0;
        #23;
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_err",  {7'd0, error}, 8'd0);
        check("rst_dout", data_out, 8'h00);
        check("rst_wen",  {7'd0, fifo_en}, 8'd0);
        rstn = 1'b1;
        idle(2);

        // Good packet
        send(8'h43, 1'b1); check("good_busy_hdr", {7'd0, busy}, 8'd1);
        send(8'h11, 1'b1); check("good_busy_p1", {7'd0, busy}, 8'd1);
        send(8'h22, 1'b1);
        send(8'h33, 1'b1); check("good_busy_p3", {7'd0, busy}, 8'd1);
        send(8'h43, 1'b1);
        check("good_busy_end", {7'd0, busy}, 8'd0);
        check("good_err", {7'd0, error}, 8'd0);
        idle(2);
        check("good_q_empty", 8'(exp_q.size()), 8'd0);

        // Bad parity, then blocked header, clear, then accepted packet
        send(8'h43, 1'b1); send(8'h11, 1'b1); send(8'h22, 1'b1); send(8'h33, 1'b1);
        send(8'h00, 1'b1);
        check("badpar_err", {7'd0, error}, 8'd1);
        check("badpar_busy", {7'd0, busy}, 8'd0);
        idle(2);
        check("badpar_sticky", {7'd0, error}, 8'd1);
        send(8'h41, 1'b0);
        check("blocked_busy", {7'd0, busy}, 8'd0);
        check("blocked_err", {7'd0, error}, 8'd1);
        idle(1);
        clear_err();
        send(8'h41, 1'b1); send(8'h55, 1'b1); send(8'h14, 1'b1);
        check("after_clr_err", {7'd0, error}, 8'd0);
        idle(2);
        check("badpar_q_empty", 8'(exp_q.size()), 8'd0);

        // Zero-length header
        send(8'h40, 1'b0);
        check("zlen_err", {7'd0, error}, 8'd1);
        check("zlen_busy", {7'd0, busy}, 8'd0);
        idle(1);
        clear_err();

        // Stall inside the payload
        send(8'h43, 1'b1); send(8'h11, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("stall_busy", {7'd0, busy}, 8'd1);
        end
        send(8'h22, 1'b1); send(8'h33, 1'b1); send(8'h43, 1'b1);
        check("stall_err", {7'd0, error}, 8'd0);
        check("stall_busy_end", {7'd0, busy}, 8'd0);
        idle(2);
        check("stall_q_empty", 8'(exp_q.size()), 8'd0);

        // Asynchronous reset mid-packet
        send(8'h43, 1'b1); send(8'h11, 1'b1);
        @(negedge clk); #1;
        rstn = 1'b0;
        #1;
        check("midrst_busy", {7'd0, busy}, 8'd0);
        check("midrst_wen",  {7'd0, fifo_en}, 8'd0);
        check("midrst_dout", data_out, 8'h00);
        check("midrst_err",  {7'd0, error}, 8'd0);
        @(posedge clk); #3;
        rstn = 1'b1;
        tick();
        send(8'h21, 1'b1); send(8'hAA, 1'b1); send(8'h8B, 1'b1);
        check("postrst_err", {7'd0, error}, 8'd0);
        check("postrst_busy", {7'd0, busy}, 8'd0);
        idle(2);
        check("postrst_q_empty", 8'(exp_q.size()), 8'd0);

        // Error event coincides with clear
        send(8'h43, 1'b1); send(8'h11, 1'b1); send(8'h22, 1'b1); send(8'h33, 1'b1);
        clr_errors = 1'b1;
        send(8'h00, 1'b1);
        clr_errors = 1'b0;
        check("err_vs_clr", {7'd0, error}, 8'd1);
        idle(2);
        clear_err();
        check("final_q_empty", 8'(exp_q.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
